// File: rtl/riscv_dbg_pkg.sv
// Shared debug-monitor definitions: FSM encodings, the memory-mapped I/O
// window tag used by the store tracer, and a width-generic byte swap.
package riscv_dbg_pkg;

  // Run-control states; the encoding is visible on the STATE debug port.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_FIN   = 2'd3
  } mon_state_t;

  // Upper address bits [31:20] that identify the I/O window (0x001xxxxx).
  localparam logic [11:0] IO_WINDOW = 12'h001;

  // Widest data word the byte swap supports.
  localparam int MAX_DATA_W = 256;

  // Reverse the byte order of the low nbytes bytes of d: byte 0 ends up in
  // the most significant byte position of the nbytes-wide result.
  function automatic logic [MAX_DATA_W-1:0] byteswap(
    input logic [MAX_DATA_W-1:0] d,
    input int                    nbytes
  );
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (i < nbytes) begin
        r[8*(nbytes-1-i) +: 8] = d[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_dump_walker.sv
// Dump-window walker: issues word reads over a req/ack port starting at
// DUMP_BASE, keeps the request up across back-to-back acks, and republishes
// each returned word (byte-reversed) as a one-cycle strobe.
module sim_dump_walker
  import riscv_dbg_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
  parameter int                DUMP_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              last_ack,
  output logic              done
);

  localparam int                IDX_W     = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DUMP_WORDS - 1);
  localparam logic [ADDR_W-3:0] BASE_WORD = DUMP_BASE[ADDR_W-1:2];

  logic              mem_req_reg;
  logic [ADDR_W-3:0] mem_addr_reg;
  logic [IDX_W-1:0]  index_reg;
  logic              dump_valid_reg;
  logic [ADDR_W-1:0] dump_addr_reg;
  logic [DATA_W-1:0] dump_data_reg;
  logic              done_reg;

  logic                  take;
  logic [MAX_DATA_W-1:0] rdata_ext;
  logic [MAX_DATA_W-1:0] rdata_swap;

  // An ack only counts while a request is outstanding, so stray acks in
  // other states are ignored without extra qualification.
  assign take     = mem_req_reg & mem_ack;
  assign last_ack = take & (index_reg == LAST_IDX);

  assign rdata_ext  = MAX_DATA_W'(mem_rdata);
  assign rdata_swap = byteswap(rdata_ext, DATA_W / 8);

  // Request/address walk, captured dump word and sticky done flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      index_reg      <= '0;
      dump_valid_reg <= 1'b0;
      dump_addr_reg  <= '0;
      dump_data_reg  <= '0;
      done_reg       <= 1'b0;
    end else begin
      dump_valid_reg <= take;
      if (start) begin
        mem_req_reg  <= 1'b1;
        mem_addr_reg <= BASE_WORD;
        index_reg    <= '0;
      end else if (take) begin
        // Word address times four is DUMP_BASE + 4*index modulo 2^ADDR_W.
        dump_addr_reg <= {mem_addr_reg, 2'b00};
        dump_data_reg <= DATA_W'(rdata_swap);
        if (index_reg == LAST_IDX) begin
          mem_req_reg <= 1'b0;
          done_reg    <= 1'b1;
        end else begin
          index_reg    <= index_reg + IDX_W'(1);
          mem_addr_reg <= mem_addr_reg + (ADDR_W-2)'(1);
        end
      end
    end
  end

  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;
  assign dump_valid = dump_valid_reg;
  assign dump_addr  = dump_addr_reg;
  assign dump_data  = dump_data_reg;
  assign done       = done_reg;

endmodule

// File: rtl/sim_run_monitor.sv
// Run-control and memory-dump monitor for a RISC-V core. Detects the halt
// fetch address or a cycle-watchdog expiry, optionally lets the pipeline
// drain, then walks a data-memory window through sim_dump_walker.
// Optional store tracer for the I/O window: define SIM_RUN_MONITOR_ST_TRACE_EN.
module sim_run_monitor
  import riscv_dbg_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] HALT_PC     = ADDR_W'(32'h0000_0064),
  parameter int                DRAIN_CYC   = 4,
  parameter longint            TIMEOUT_CYC = 400000000,
  parameter logic [ADDR_W-1:0] DUMP_BASE   = '0,
  parameter int                DUMP_WORDS  = 1024,
  parameter int                CNT_W       = 40
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef SIM_RUN_MONITOR_ST_TRACE_EN
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_hit,
  output logic [ADDR_W-1:0] st_hit_addr,
  output logic [DATA_W-1:0] st_hit_data,
  output logic [31:0]       st_count,
`endif
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              halted,
  output logic              timeout,
  output logic              done,
  output logic [CNT_W-1:0]  cycles,
  output logic [1:0]        state
);

  localparam logic             NO_DRAIN   = (DRAIN_CYC == 0);
  localparam logic [31:0]      DRAIN_LAST = (DRAIN_CYC > 0) ? 32'(DRAIN_CYC - 1) : 32'd0;
  localparam logic             TO_EN      = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST    = (TIMEOUT_CYC != 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  mon_state_t       state_reg;
  logic             halted_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] cycles_reg;
  logic [31:0]      drain_cnt_reg;

  logic halt_hit;
  logic to_hit;
  logic drain_end;
  logic go_dump;
  logic walk_last;

  // Halt has priority over a watchdog expiry landing in the same cycle.
  assign halt_hit  = (state_reg == ST_RUN) & pc_valid & (pc == HALT_PC);
  assign to_hit    = (state_reg == ST_RUN) & TO_EN & (cycles_reg == TO_LAST) & ~halt_hit;
  assign drain_end = (state_reg == ST_DRAIN) & (drain_cnt_reg == DRAIN_LAST);
  assign go_dump   = (halt_hit & NO_DRAIN) | to_hit | drain_end;

  // Run/drain/dump/fin control with the sticky halt and timeout flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_RUN;
      halted_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
      cycles_reg    <= '0;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          // The cycle count freezes on the edge that leaves RUN, so a
          // timeout reports TIMEOUT_CYC-1.
          if (halt_hit) begin
            halted_reg    <= 1'b1;
            drain_cnt_reg <= '0;
            state_reg     <= NO_DRAIN ? ST_DUMP : ST_DRAIN;
          end else if (to_hit) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_DUMP;
          end else if (cycles_reg != '1) begin
            cycles_reg <= cycles_reg + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            state_reg <= ST_DUMP;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 32'd1;
          end
        end
        ST_DUMP: begin
          if (walk_last) begin
            state_reg <= ST_FIN;
          end
        end
        ST_FIN: begin
          state_reg <= ST_FIN;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  sim_dump_walker #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DUMP_BASE  (DUMP_BASE),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_walker (
    .clk        (clk),
    .rstn       (rstn),
    .start      (go_dump),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .last_ack   (walk_last),
    .done       (done)
  );

`ifdef SIM_RUN_MONITOR_ST_TRACE_EN
  logic              st_hit_reg;
  logic [ADDR_W-1:0] st_hit_addr_reg;
  logic [DATA_W-1:0] st_hit_data_reg;
  logic [31:0]       st_count_reg;
  logic              st_take;

  // Only stores made while the program is still running or draining count.
  assign st_take = st_valid
                 & (st_addr[ADDR_W-1:20] == (ADDR_W-20)'(IO_WINDOW))
                 & ((state_reg == ST_RUN) | (state_reg == ST_DRAIN));

  // Capture I/O-window stores and keep a saturating hit count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_hit_reg      <= 1'b0;
      st_hit_addr_reg <= '0;
      st_hit_data_reg <= '0;
      st_count_reg    <= '0;
    end else begin
      st_hit_reg <= st_take;
      if (st_take) begin
        st_hit_addr_reg <= st_addr;
        st_hit_data_reg <= st_data;
        if (st_count_reg != '1) begin
          st_count_reg <= st_count_reg + 32'd1;
        end
      end
    end
  end

  assign st_hit      = st_hit_reg;
  assign st_hit_addr = st_hit_addr_reg;
  assign st_hit_data = st_hit_data_reg;
  assign st_count    = st_count_reg;
`endif

  assign halted  = halted_reg;
  assign timeout = timeout_reg;
  assign cycles  = cycles_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_sim_run_monitor.sv
// Directed bench for sim_run_monitor: halt-triggered dump, watchdog dump,
// halt/timeout tie, slow memory acks, and reset in the middle of a dump.
module tb_sim_run_monitor;

  logic        clk;
  logic        rstn;
  logic [31:0] pc;
  logic        pc_valid;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        halted;
  logic        timeout;
  logic        done;
  logic [39:0] cycles;
  logic [1:0]  state;
`ifdef SIM_RUN_MONITOR_ST_TRACE_EN
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_hit;
  logic [31:0] st_hit_addr;
  logic [31:0] st_hit_data;
  logic [31:0] st_count;
`endif

  int checks = 0;
  int errors = 0;

  // Memory responder controls.
  bit ack_tie   = 1'b1;
  int ack_delay = 0;
  int wait_cnt  = 0;

  // Expected byte-swapped words for mem words 0x40..0x43 (0x11223344+i).
  logic [31:0] exp_swap [4] = '{32'h44332211, 32'h45332211, 32'h46332211, 32'h47332211};

  sim_run_monitor #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .HALT_PC     (32'h0000_0064),
    .DRAIN_CYC   (2),
    .TIMEOUT_CYC (20),
    .DUMP_BASE   (32'h0000_0100),
    .DUMP_WORDS  (4),
    .CNT_W       (40)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
`ifdef SIM_RUN_MONITOR_ST_TRACE_EN
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_hit      (st_hit),
    .st_hit_addr (st_hit_addr),
    .st_hit_data (st_hit_data),
    .st_count    (st_count),
`endif
    .dump_valid  (dump_valid),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .halted      (halted),
    .timeout     (timeout),
    .done        (done),
    .cycles      (cycles),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'h11223344 + {2'b00, a} - 32'h40;
  endfunction

  // Memory model: either acks every cycle, or acks after ack_delay wait cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = mem_word(mem_addr);
      if (ack_tie) begin
        mem_ack = 1'b1;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    pc       = '0;
    pc_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Present the halt PC for one cycle, then wait out the two drain cycles.
  task automatic do_halt();
    pc_valid = 1'b1;
    pc       = 32'h64;
    tick();
    pc = 32'h68;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstn     = 1'b1;
    pc       = '0;
    pc_valid = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    checks++; if (mem_addr !== 30'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (dump_valid !== 1'b0 || dump_addr !== 32'd0 || dump_data !== 32'd0) begin
      errors++; $display("FAIL reset_dump: got v=%0b a=%h d=%h want 0", dump_valid, dump_addr, dump_data); end
    checks++; if (halted !== 1'b0 || timeout !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got h=%0b t=%0b d=%0b want 0", halted, timeout, done); end
    checks++; if (cycles !== 40'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
    $display("reset: outputs checked");
  endtask

  task automatic test_halt_dump();
    ack_tie = 1'b1;
    apply_reset();
    pc_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc = 32'h20 + 32'(4 * k);
      tick();
    end
    checks++; if (cycles !== 40'd5) begin errors++; $display("FAIL run_cycles: got %0d want 5", cycles); end
    checks++; if (state !== 2'd0 || mem_req !== 1'b0 || dump_valid !== 1'b0) begin
      errors++; $display("FAIL run_idle: got st=%0d req=%0b v=%0b want 0/0/0", state, mem_req, dump_valid); end
    pc = 32'h64;
    tick();
    checks++; if (halted !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL halt_seen: got h=%0b st=%0d want 1/1", halted, state); end
    pc = 32'h68;
    tick();
    checks++; if (state !== 2'd1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL drain_hold: got st=%0d req=%0b want 1/0", state, mem_req); end
    tick();
    checks++; if (state !== 2'd2 || mem_req !== 1'b1 || mem_addr !== 30'h40) begin
      errors++; $display("FAIL dump_start: got st=%0d req=%0b a=%h want 2/1/40", state, mem_req, mem_addr); end
    for (int w = 0; w < 4; w++) begin
      tick();
      $display("dump addr=%08h data=%08h", dump_addr, dump_data);
      checks++; if (dump_valid !== 1'b1 || dump_addr !== 32'h100 + 32'(4 * w) || dump_data !== exp_swap[w]) begin
        errors++; $display("FAIL halt_word%0d: got v=%0b a=%h d=%h want 1/%h/%h",
                           w, dump_valid, dump_addr, dump_data, 32'h100 + 32'(4 * w), exp_swap[w]); end
      if (w < 3) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h41 + 30'(w)) begin
          errors++; $display("FAIL halt_next_req%0d: got req=%0b a=%h want 1/%h", w, mem_req, mem_addr, 30'h41 + 30'(w)); end
      end else begin
        checks++; if (state !== 2'd3 || done !== 1'b1 || mem_req !== 1'b0) begin
          errors++; $display("FAIL halt_fin: got st=%0d done=%0b req=%0b want 3/1/0", state, done, mem_req); end
      end
    end
    pc = 32'h64;
    tick();
    tick();
    checks++; if (dump_valid !== 1'b0 || done !== 1'b1 || state !== 2'd3 || timeout !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL fin_hold: got v=%0b done=%0b st=%0d t=%0b h=%0b want 0/1/3/0/1",
                         dump_valid, done, state, timeout, halted); end
  endtask

  task automatic test_timeout();
    int strobes;
    ack_tie = 1'b1;
    apply_reset();
    pc_valid = 1'b0;
    pc       = 32'h64;
    for (int k = 0; k < 19; k++) tick();
    checks++; if (cycles !== 40'd19 || state !== 2'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL to_before: got c=%0d st=%0d t=%0b want 19/0/0", cycles, state, timeout); end
    tick();
    checks++; if (timeout !== 1'b1 || state !== 2'd2 || mem_req !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL to_fire: got t=%0b st=%0d req=%0b h=%0b want 1/2/1/0", timeout, state, mem_req, halted); end
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dump_valid) begin
        $display("dump addr=%08h data=%08h", dump_addr, dump_data);
        strobes++;
      end
    end
    checks++; if (strobes != 4 || done !== 1'b1) begin
      errors++; $display("FAIL to_dump: got strobes=%0d done=%0b want 4/1", strobes, done); end
    checks++; if (cycles !== 40'd19 || halted !== 1'b0) begin
      errors++; $display("FAIL to_frozen: got c=%0d h=%0b want 19/0", cycles, halted); end
  endtask

  task automatic test_halt_timeout_tie();
    ack_tie = 1'b1;
    apply_reset();
    pc_valid = 1'b1;
    pc       = 32'h0;
    for (int k = 0; k < 19; k++) tick();
    pc = 32'h64;
    tick();
    checks++; if (halted !== 1'b1 || timeout !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL tie_halt_wins: got h=%0b t=%0b st=%0d want 1/0/1", halted, timeout, state); end
    pc = 32'h0;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (done !== 1'b1 || timeout !== 1'b0 || state !== 2'd3) begin
      errors++; $display("FAIL tie_finish: got done=%0b t=%0b st=%0d want 1/0/3", done, timeout, state); end
    $display("halt/timeout tie: halted=%0b timeout=%0b", halted, timeout);
  endtask

  task automatic test_slow_ack();
    ack_tie   = 1'b0;
    ack_delay = 2;
    apply_reset();
    do_halt();
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 3; c++) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h40 + 30'(w)) begin
          errors++; $display("FAIL slow_req w%0d c%0d: got req=%0b a=%h want 1/%h", w, c, mem_req, mem_addr, 30'h40 + 30'(w)); end
        tick();
        if (c == 2) begin
          $display("dump addr=%08h data=%08h", dump_addr, dump_data);
          checks++; if (dump_valid !== 1'b1 || dump_addr !== 32'h100 + 32'(4 * w) || dump_data !== exp_swap[w]) begin
            errors++; $display("FAIL slow_word%0d: got v=%0b a=%h d=%h want 1/%h/%h",
                               w, dump_valid, dump_addr, dump_data, 32'h100 + 32'(4 * w), exp_swap[w]); end
        end else begin
          checks++; if (dump_valid !== 1'b0) begin
            errors++; $display("FAIL slow_nostrobe w%0d c%0d: got %0b want 0", w, c, dump_valid); end
        end
      end
    end
    checks++; if (state !== 2'd3 || done !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL slow_fin: got st=%0d done=%0b req=%0b want 3/1/0", state, done, mem_req); end
    tick();
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL slow_extra_strobe: got %0b want 0", dump_valid); end
  endtask

  task automatic test_reset_mid_dump();
    ack_tie   = 1'b0;
    ack_delay = 2;
    apply_reset();
    do_halt();
    for (int k = 0; k < 6; k++) tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h42) begin
      errors++; $display("FAIL mid_index2: got req=%0b a=%h want 1/42", mem_req, mem_addr); end
    rstn = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || state !== 2'd0 || mem_addr !== 30'd0) begin
      errors++; $display("FAIL mid_abort: got req=%0b st=%0d a=%h want 0/0/0", mem_req, state, mem_addr); end
    checks++; if (halted !== 1'b0 || timeout !== 1'b0 || done !== 1'b0 || dump_valid !== 1'b0 || cycles !== 40'd0) begin
      errors++; $display("FAIL mid_flags: got h=%0b t=%0b d=%0b v=%0b c=%0d want 0", halted, timeout, done, dump_valid, cycles); end
    ack_tie = 1'b1;
    tick();
    rstn = 1'b1;
    do_halt();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h40) begin
      errors++; $display("FAIL rerun_start: got req=%0b a=%h want 1/40", mem_req, mem_addr); end
    tick();
    $display("dump addr=%08h data=%08h", dump_addr, dump_data);
    checks++; if (dump_valid !== 1'b1 || dump_addr !== 32'h100 || dump_data !== 32'h44332211) begin
      errors++; $display("FAIL rerun_word0: got v=%0b a=%h d=%h want 1/100/44332211", dump_valid, dump_addr, dump_data); end
  endtask

`ifdef SIM_RUN_MONITOR_ST_TRACE_EN
  task automatic test_st_trace();
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ack_tie  = 1'b1;
    apply_reset();
    st_valid = 1'b1;
    st_addr  = 32'h0010_0004;
    st_data  = 32'h41;
    tick();
    checks++; if (st_hit !== 1'b1 || st_hit_addr !== 32'h0010_0004 || st_hit_data !== 32'h41 || st_count !== 32'd1) begin
      errors++; $display("FAIL st_io_hit: got hit=%0b a=%h d=%h n=%0d want 1/00100004/41/1", st_hit, st_hit_addr, st_hit_data, st_count); end
    st_addr = 32'h0000_0010;
    st_data = 32'h99;
    tick();
    st_valid = 1'b0;
    checks++; if (st_hit !== 1'b0 || st_hit_addr !== 32'h0010_0004 || st_count !== 32'd1) begin
      errors++; $display("FAIL st_miss: got hit=%0b a=%h n=%0d want 0/00100004/1", st_hit, st_hit_addr, st_count); end
    $display("store trace: count=%0d", st_count);
  endtask
`endif

  initial begin
`ifdef SIM_RUN_MONITOR_ST_TRACE_EN
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
`endif
    test_reset();
    test_halt_dump();
    test_timeout();
    test_halt_timeout_tie();
    test_slow_ack();
    test_reset_mid_dump();
`ifdef SIM_RUN_MONITOR_ST_TRACE_EN
    test_st_trace();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_run_monitor.md
Name: sim_run_monitor

Overview:
- Parametrised, synthesizable run-control and memory-dump monitor, attached beside the riscv core in the testbench or an FPGA debug wrapper.
- Watches the fetch PC for the halt address and runs a cycle watchdog.
- On halt or timeout, walks a configurable data-memory window over a req/ack read port and streams byte-swapped words out for printing or capture.
- Generalises the fixed "PC==0x64 then dump 1024 words" bench logic: halt PC, timeout, dump base and dump length are all configurable, and memory latency is arbitrary.

Parameters:
- ADDR_W, 32, byte-address width of PC and dump addresses.
- DATA_W, 32, memory word width; must be a multiple of 8.
- HALT_PC, 32'h00000064, fetch address that signals program end (ebreak).
- DRAIN_CYC, 4, cycles waited after halt before dumping, so the pipeline can retire stores; 0 is legal.
- TIMEOUT_CYC, 400000000, watchdog limit in cycles; 0 disables the watchdog.
- DUMP_BASE, 0, byte address of the first dumped word; word-aligned.
- DUMP_WORDS, 1024, number of words to dump; must be at least 1.
- CNT_W, 40, width of the cycle counter.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- PC  in  ADDR_W  fetch PC (PC_IF on the pipeline core, PC on the origin core).
- PC_VALID  in  1  PC qualifies this cycle.
- MEM_REQ  out  1  dump read request.
- MEM_ADDR  out  ADDR_W-2  dump word address.
- MEM_ACK  in  1  read complete; MEM_RDATA is valid in the same cycle.
- MEM_RDATA  in  DATA_W  read data.
- DUMP_VALID  out  1  one-cycle strobe carrying a dump word.
- DUMP_ADDR  out  ADDR_W  byte address of the dumped word.
- DUMP_DATA  out  DATA_W  MEM_RDATA byte-reversed (byte0 in the MSBs).
- HALTED  out  1  halt PC was seen; sticky.
- TIMEOUT  out  1  watchdog expired; sticky.
- DONE  out  1  dump finished; sticky until reset.
- CYCLES  out  CNT_W  cycles counted in RUN state.
- STATE  out  2  current FSM state, for debug.

Behaviour:
- Reset (async, RSTN=0): state=RUN; every output is 0; internal word index=0; CYCLES=0.
- State encodings: RUN=0, DRAIN=1, DUMP=2, FIN=3.
- RUN:
  - CYCLES increments every cycle and saturates at all-ones.
  - If PC_VALID and PC==HALT_PC: HALTED<=1 next edge, drain counter<=0, go to DRAIN (go straight to DUMP if DRAIN_CYC==0).
  - Else if TIMEOUT_CYC!=0 and CYCLES==TIMEOUT_CYC-1: TIMEOUT<=1, go to DUMP with no drain.
  - Halt and timeout on the same cycle: halt wins; TIMEOUT stays 0.
- DRAIN: counts DRAIN_CYC cycles, then goes to DUMP. CYCLES is frozen; PC is ignored.
- DUMP:
  - MEM_REQ=1; MEM_ADDR=DUMP_BASE[ADDR_W-1:2]+index.
  - MEM_REQ and MEM_ADDR stay stable until MEM_ACK.
  - On the ACK cycle, registered for the next cycle: DUMP_VALID=1, DUMP_ADDR=DUMP_BASE+4*index, DUMP_DATA=byteswap(MEM_RDATA).
  - After the ACK, index increments. MEM_REQ stays high for the next word, giving back-to-back ACKs 1 word/cycle.
  - ACK for index DUMP_WORDS-1: MEM_REQ drops in the next cycle; go to FIN.
  - Address arithmetic wraps modulo 2^ADDR_W; no error is raised.
- FIN: DONE=1, MEM_REQ=0, outputs hold. Leaves FIN only on reset.
- MEM_ACK outside DUMP is ignored.
- Reset asserted mid-dump aborts immediately: MEM_REQ falls asynchronously; the next run restarts at index 0.
- Latency: halt PC seen at edge N gives the first MEM_REQ at edge N+1+DRAIN_CYC.

Optional Feature:
- Macro SIM_RUN_MONITOR_ST_TRACE_EN.
- When defined, adds these inputs:
  - ST_VALID  in  1
  - ST_ADDR  in  ADDR_W
  - ST_DATA  in  DATA_W
- When defined, adds these outputs:
  - ST_HIT  out  1  registered one-cycle strobe.
  - ST_HIT_ADDR  out  ADDR_W
  - ST_HIT_DATA  out  DATA_W
  - ST_COUNT  out  32  saturating.
- A store hits when ST_VALID=1 and ST_ADDR[ADDR_W-1:20]==12'h001 (I/O window). Each hit updates the outputs one cycle later.
- Hits are counted in RUN and DRAIN only.
- When undefined, these ports and registers do not exist.

Decomposition:
- Shared package riscv_dbg_pkg:
  - State encodings (RUN/DRAIN/DUMP/FIN).
  - Byte-swap function.
  - I/O window constant 12'h001.
- One natural sub-module, sim_dump_walker: the DUMP-state req/ack address walker with index counter and done flag. The parent keeps run/halt/watchdog control.

Test Plan:
- HALT_PC=0x64, DRAIN_CYC=2, DUMP_WORDS=4, MEM_ACK tied 1, mem[0..3]=0x11223344+i: drive PC=0x64 at cycle 10 -> HALTED at 11; MEM_REQ from 13; DUMP_VALID at addr 0,4,8,C with data 0x44332211 etc.; DONE after the 4th word; STATE=3.
- TIMEOUT_CYC=20, PC never 0x64 -> TIMEOUT=1 with CYCLES=19 frozen; HALTED=0; dump proceeds.
- PC=0x64 on cycle 19 with TIMEOUT_CYC=20 -> HALTED=1, TIMEOUT=0.
- MEM_ACK delayed 3 cycles per word, DUMP_BASE=0x100 -> MEM_ADDR=0x40 held 3 cycles, then 0x41; DUMP_ADDR=0x100, 0x104; exactly DUMP_WORDS strobes.
- RSTN pulsed low mid-DUMP at index 2 -> MEM_REQ=0 immediately; all flags 0; rerun dumps from index 0.
- With SIM_RUN_MONITOR_ST_TRACE_EN: stores to 0x00100004 (data 0x41) and 0x00000010 -> one ST_HIT with addr 0x00100004, data 0x41; ST_COUNT=1.
